ps2_host_tx: RTL

- Parametrised PS/2 host-to-device transmitter for the mouse/keyboard path.
- Accepts one command byte per valid/ready handshake and computes odd parity internally.
- Performs inhibit → request-to-send → 11-bit device-clocked transfer → ACK check, with watchdog timeouts and coded errors.
- Drives PS2C/PS2D as open-drain enables. Sits between the command sequencer and the board-level open-drain pads.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_us_tick.sv | 37 +++
 rtl/ps2_host_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter (and the planned receiver).
// Contents: FSM state encoding, transaction error codes, frame length, and
// the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_RTS     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACKWAIT = 3'd4,
        ST_FAIL    = 3'd5
    } ps2_state_e;

    typedef enum logic [1:0] {
        ERR_OK     = 2'b00,
        ERR_RTS_TO = 2'b01,
        ERR_PKT_TO = 2'b10,
        ERR_NACK   = 2'b11
    } ps2_err_e;

    // start + 8 data + parity + stop, with the ACK sampled on the 11th edge
    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_us_tick.sv
// 1 us tick generator: free-running divider of the system clock.
// Ports:
//   qzt_clk  - system clock
//   reset_n  - asynchronous active-low reset
//   restart  - synchronous restart; next tick comes a full period later
//   tick     - one-cycle pulse every CLK_HZ/1e6 cycles
module ps2_us_tick #(
    parameter int CLK_HZ = 50000000
) (
    input  logic qzt_clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);
    localparam int DIV   = (CLK_HZ / 1000000) < 1 ? 1 : (CLK_HZ / 1000000);
    localparam int CNT_W = DIV > 1 ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Takes one command byte per valid/ready
// handshake, inhibits the bus, requests to send, shifts the 11-bit frame on
// device clock falling edges and checks the device ACK, with watchdogs.
// Ports:
//   qzt_clk, reset_n     - clock, asynchronous active-low reset
//   tx_data/tx_valid     - command byte and request; tx_ready high in IDLE
//   ps2c_in, ps2d_in     - raw pad levels (asynchronous)
//   ps2c_oe, ps2d_oe     - open-drain pull-low enables
//   busy, done, err,
//   err_code             - status; err/err_code qualified by done
// Optional build macro: PS2_TX_RESEND_EN (retry NACKed bytes up to MAX_RETRY).
//
// state   | meaning
// IDLE    | lines released, ready for a byte
// INHIBIT | PS2C held low, then start bit driven before PS2C release
// RTS     | waiting for the device's first clock falling edge
// SHIFT   | driving data/parity/stop, sampling ACK on the 11th edge
// ACKWAIT | waiting for both lines to return high
// FAIL    | lines released, error reported on the way back to IDLE
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ            = 50000000,
    parameter int INHIBIT_US        = 100,
    parameter int RTS_TIMEOUT_US    = 15000,
    parameter int PACKET_TIMEOUT_US = 2000,
    parameter int SYNC_STAGES       = 2,
    parameter int MAX_RETRY         = 3
) (
    input  logic       qzt_clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int MAX_A = INHIBIT_US > RTS_TIMEOUT_US ? INHIBIT_US : RTS_TIMEOUT_US;
    localparam int MAX_T = MAX_A > PACKET_TIMEOUT_US ? MAX_A : PACKET_TIMEOUT_US;
    localparam int TMR_W = $clog2(MAX_T) + 1;

    ps2_state_e state_q, state_d;
    ps2_err_e   fail_code_q, fail_code_d, err_code_q, err_code_d;
    logic [SYNC_STAGES-1:0] c_sync_q, c_sync_d, d_sync_q, d_sync_d;
    logic       c_prev_q, c_prev_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0] data_q, data_d;
    logic       parity_q, parity_d;
    logic [3:0] bit_idx_q, bit_idx_d, nxt_idx;
    logic       dval_q, dval_d;
    logic       inh_start_q, inh_start_d;
    logic       rdy_en_q, rdy_en_d;
    logic       done_q, done_d, err_q, err_d;
    logic       c_s, d_s, fe, tick, tmr_zero;
`ifdef PS2_TX_RESEND_EN
    localparam int RTY_W = $clog2(MAX_RETRY + 1) < 1 ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0] retry_q, retry_d;
`endif

    ps2_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .qzt_clk (qzt_clk),
        .reset_n (reset_n),
        .restart (state_d != state_q),
        .tick    (tick)
    );

    assign c_s      = c_sync_q[SYNC_STAGES-1];
    assign d_s      = d_sync_q[SYNC_STAGES-1];
    assign fe       = c_prev_q & ~c_s;
    assign tmr_zero = (tmr_q == '0);
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            fail_code_q <= ERR_OK;
            err_code_q  <= ERR_OK;
            c_sync_q    <= '1;
            d_sync_q    <= '1;
            c_prev_q    <= 1'b1;
            tmr_q       <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            bit_idx_q   <= '0;
            dval_q      <= 1'b1;
            inh_start_q <= 1'b0;
            rdy_en_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            err_code_q  <= err_code_d;
            c_sync_q    <= c_sync_d;
            d_sync_q    <= d_sync_d;
            c_prev_q    <= c_prev_d;
            tmr_q       <= tmr_d;
            data_q      <= data_d;
            parity_q    <= parity_d;
            bit_idx_q   <= bit_idx_d;
            dval_q      <= dval_d;
            inh_start_q <= inh_start_d;
            rdy_en_q    <= rdy_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        c_sync_d    = {c_sync_q[SYNC_STAGES-2:0], ps2c_in};
        d_sync_d    = {d_sync_q[SYNC_STAGES-2:0], ps2d_in};
        c_prev_d    = c_s;
        rdy_en_d    = 1'b1;
        state_d     = state_q;
        fail_code_d = fail_code_q;
        err_code_d  = err_code_q;
        data_d      = data_q;
        parity_d    = parity_q;
        bit_idx_d   = bit_idx_q;
        nxt_idx     = bit_idx_q + 4'd1;
        dval_d      = dval_q;
        inh_start_d = inh_start_q;
        done_d      = 1'b0;
        err_d       = err_q;
`ifdef PS2_TX_RESEND_EN
        retry_d     = retry_q;
`endif
        // down-counter in 1 us ticks, holds at zero
        tmr_d = tmr_q;
        if (tick && !tmr_zero) begin
            tmr_d = tmr_q - TMR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && rdy_en_q) begin
                    data_d      = tx_data;
                    parity_d    = odd_parity(tx_data);
                    inh_start_d = 1'b0;
                    tmr_d       = TMR_W'(INHIBIT_US);
                    state_d     = ST_INHIBIT;
`ifdef PS2_TX_RESEND_EN
                    retry_d     = '0;
`endif
                end
            end
            ST_INHIBIT: begin
                // start bit goes low one cycle before PS2C is released
                if (inh_start_q) begin
                    inh_start_d = 1'b0;
                    tmr_d       = TMR_W'(RTS_TIMEOUT_US);
                    state_d     = ST_RTS;
                end else if (tmr_zero) begin
                    inh_start_d = 1'b1;
                end
            end
            ST_RTS: begin
                if (fe) begin
                    bit_idx_d = 4'd1;
                    dval_d    = data_q[0];
                    tmr_d     = TMR_W'(PACKET_TIMEOUT_US);
                    state_d   = ST_SHIFT;
                end else if (tmr_zero) begin
                    fail_code_d = ERR_RTS_TO;
                    state_d     = ST_FAIL;
                end
            end
            ST_SHIFT: begin
                if (tmr_zero) begin
                    fail_code_d = ERR_PKT_TO;
                    state_d     = ST_FAIL;
                end else if (fe) begin
                    bit_idx_d = nxt_idx;
                    if (nxt_idx <= 4'd8) begin
                        dval_d = data_q[bit_idx_q[2:0]];
                    end else if (nxt_idx == 4'd9) begin
                        dval_d = parity_q;
                    end else if (nxt_idx == 4'd10) begin
                        dval_d = 1'b1;
                    end else if (nxt_idx == 4'(PS2_FRAME_BITS)) begin
                        if (!d_s) begin
                            state_d = ST_ACKWAIT;
                        end else begin
`ifdef PS2_TX_RESEND_EN
                            if (retry_q < RTY_W'(MAX_RETRY)) begin
                                retry_d     = retry_q + RTY_W'(1);
                                inh_start_d = 1'b0;
                                tmr_d       = TMR_W'(INHIBIT_US);
                                state_d     = ST_INHIBIT;
                            end else begin
                                fail_code_d = ERR_NACK;
                                state_d     = ST_FAIL;
                            end
`else
                            fail_code_d = ERR_NACK;
                            state_d     = ST_FAIL;
`endif
                        end
                    end
                end
            end
            ST_ACKWAIT: begin
                // packet timer keeps running from the SHIFT phase
                if (tmr_zero) begin
                    fail_code_d = ERR_PKT_TO;
                    state_d     = ST_FAIL;
                end else if (c_s && d_s) begin
                    done_d     = 1'b1;
                    err_d      = 1'b0;
                    err_code_d = ERR_OK;
                    state_d    = ST_IDLE;
                end
            end
            ST_FAIL: begin
                done_d     = 1'b1;
                err_d      = 1'b1;
                err_code_d = fail_code_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = 1'b0;
        busy     = 1'b0;
        ps2c_oe  = 1'b0;
        ps2d_oe  = 1'b0;
        case (state_q)
            ST_IDLE:    tx_ready = rdy_en_q;
            ST_INHIBIT: begin
                busy    = 1'b1;
                ps2c_oe = 1'b1;
                ps2d_oe = inh_start_q;
            end
            ST_RTS: begin
                busy    = 1'b1;
                ps2d_oe = 1'b1;
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                ps2d_oe = ~dval_q;
            end
            ST_ACKWAIT, ST_FAIL: busy = 1'b1;
            default: ;
        endcase
    end

endmodule
